line_fill_responder: RTL and testbench

Backend-side responder for the LRU cache way. It accepts line-fill requests (tags) on a stream slave and fetches the full CACHE_SIZE-bit line from a DATA_WIDTH-wide backing-memory read port. The fetch is pipelined, with up to BEATS reads in flight. It returns the assembled line on a stream master. It sits between the cache way's backend stream pair and the on-card memory controller.

---
 rtl/line_fill_pkg.sv | 29 ++
 rtl/line_fill_responder_sync_fifo.sv | 66 ++++++
 rtl/line_fill_responder.sv | 158 +++++++++++++++
 tb/tb_line_fill_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_fill_pkg.sv
// Shared types and helpers for the cache-way backend: FSM encoding, default line
// geometry and a ceil-log2 helper usable in parameter expressions.
package line_fill_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } fsm_t;

  // Returns ceil(log2(value)); used for pointer and beat-index widths.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int DEF_CACHE_SIZE = 512;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_BEATS      = DEF_CACHE_SIZE / DEF_DATA_WIDTH;
  localparam int DEF_BEAT_BITS  = clogb2(DEF_BEATS);

endpackage

// File: rtl/line_fill_responder_sync_fifo.sv
// Small synchronous FIFO with registered occupancy; full/empty depend only on
// state so no input ever reaches them combinationally.
module sync_fifo
  import line_fill_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int PTR_BITS = clogb2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                do_push;
  logic                do_pop;

  assign full    = (count_q == CNT_BITS'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_BITS'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
    end
    count_d = count_q + CNT_BITS'(do_push) - CNT_BITS'(do_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/line_fill_responder.sv
// Cache-way backend responder: queues tag requests, fetches BEATS words per line
// from backing memory with pipelined reads, and returns the assembled line.
module line_fill_responder
  import line_fill_pkg::*;
#(
  parameter  int TAGS_WIDTH     = 48,
  parameter  int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter  int CACHE_SIZE     = DEF_CACHE_SIZE,
  parameter  int REQ_FIFO_DEPTH = 4,
  parameter  int TDATA_WIDTH    = 512,
  localparam int BEATS          = CACHE_SIZE / DATA_WIDTH,
  localparam int BEAT_BITS      = clogb2(BEATS),
  localparam int ADDR_WIDTH     = TAGS_WIDTH + BEAT_BITS
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   req_tvalid,
  output logic                   req_tready,
  input  logic [TDATA_WIDTH-1:0] req_tdata,
  output logic                   rsp_tvalid,
  input  logic                   rsp_tready,
  output logic [TDATA_WIDTH-1:0] rsp_tdata,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic                   mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]  mem_rsp_data,
  output logic                   err_unexpected_rsp,
  output logic                   busy
);

  localparam int CNT_BITS = BEAT_BITS + 1;

  fsm_t                  state_q, state_d;
  logic [TAGS_WIDTH-1:0] tag_q, tag_d;
  logic [CNT_BITS-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_BITS-1:0]   rcv_cnt_q, rcv_cnt_d;
  logic [CACHE_SIZE-1:0] line_q, line_d;
  logic                  err_q, err_d;
  logic                  started_q, started_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [TAGS_WIDTH-1:0] fifo_dout;
  logic                  rsp_accept;
  logic                  unused_tdata_hi;

  assign unused_tdata_hi = ^req_tdata[TDATA_WIDTH-1:TAGS_WIDTH];

  // started_q keeps tready low until the first edge after reset release.
  assign req_tready = started_q && !fifo_full;
  assign fifo_push  = req_tvalid && req_tready;

  sync_fifo #(
    .WIDTH(TAGS_WIDTH),
    .DEPTH(REQ_FIFO_DEPTH)
  ) u_req_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (fifo_push),
    .din  (req_tdata[TAGS_WIDTH-1:0]),
    .full (fifo_full),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .empty(fifo_empty)
  );

  // Data is only taken while fetching and only for beats already issued.
  assign rsp_accept = mem_rsp_valid && (state_q == FETCH) && (rcv_cnt_q < issue_cnt_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = FETCH;
      FETCH:   if (rsp_accept && (rcv_cnt_q == CNT_BITS'(BEATS - 1))) state_d = RESP;
      RESP:    if (rsp_tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_pop      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    rsp_tvalid    = 1'b0;
    unique case (state_q)
      IDLE: fifo_pop = !fifo_empty;
      FETCH: begin
        mem_req_valid = (issue_cnt_q < CNT_BITS'(BEATS));
        mem_req_addr  = {tag_q, issue_cnt_q[BEAT_BITS-1:0]};
      end
      RESP:    rsp_tvalid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_tdata = TDATA_WIDTH'(line_q);
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign err_unexpected_rsp = err_q;

  always_comb begin
    tag_d       = tag_q;
    issue_cnt_d = issue_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;
    line_d      = line_q;
    err_d       = err_q;
    started_d   = 1'b1;
    if (fifo_pop) begin
      tag_d       = fifo_dout;
      issue_cnt_d = '0;
      rcv_cnt_d   = '0;
    end
    if (mem_req_valid && mem_req_ready) begin
      issue_cnt_d = issue_cnt_q + CNT_BITS'(1);
    end
    // Beat 0 lands in the least significant slice of the line.
    for (int b = 0; b < BEATS; b++) begin
      if (rsp_accept && (rcv_cnt_q[BEAT_BITS-1:0] == BEAT_BITS'(b))) begin
        line_d[b*DATA_WIDTH +: DATA_WIDTH] = mem_rsp_data;
      end
    end
    if (rsp_accept) begin
      rcv_cnt_d = rcv_cnt_q + CNT_BITS'(1);
    end
    if (mem_rsp_valid && !rsp_accept) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_q       <= '0;
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
      line_q      <= '0;
      err_q       <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      tag_q       <= tag_d;
      issue_cnt_q <= issue_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      line_q      <= line_d;
      err_q       <= err_d;
      started_q   <= started_d;
    end
  end

endmodule

// File: tb/tb_line_fill_responder.sv
// Randomized bench for line_fill_responder: a queue-based reference model tracks
// accepted tags, beats issued/received and the error flag, and predicts every output.
module tb_line_fill_responder;

  localparam int TW    = 48;
  localparam int DW    = 64;
  localparam int CS    = 512;
  localparam int BEATS = CS / DW;
  localparam int AW    = TW + 3;
  localparam int SW    = 512;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_tvalid = 1'b0;
  logic          req_tready;
  logic [SW-1:0] req_tdata = '0;
  logic          rsp_tvalid;
  logic          rsp_tready = 1'b0;
  logic [SW-1:0] rsp_tdata;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rsp_data = '0;
  logic          err_unexpected_rsp;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [TW-1:0] fifo_q [$];
  logic [AW-1:0] mem_pending [$];
  logic [TW-1:0] cur_tag = '0;
  bit            in_service = 0;
  int            issued = 0;
  int            received = 0;
  bit            err_exp = 0;
  bit            rdy_exp = 0;
  int            gap_cnt = 0;
  int            ready_mode = 0;
  int            max_gap = 0;

  always #5 clk = ~clk;

  line_fill_responder #(
    .TAGS_WIDTH(TW), .DATA_WIDTH(DW), .CACHE_SIZE(CS),
    .REQ_FIFO_DEPTH(DEPTH), .TDATA_WIDTH(SW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tdata(rsp_tdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .err_unexpected_rsp(err_unexpected_rsp), .busy(busy)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return DW'(a) ^ 64'hA5A5;
  endfunction

  function automatic logic [CS-1:0] expected_line(input logic [TW-1:0] tag);
    logic [CS-1:0] line;
    logic [AW-1:0] a;
    for (int i = 0; i < BEATS; i++) begin
      a = {tag, 3'(i)};
      line[i*DW +: DW] = mem_word(a);
    end
    return line;
  endfunction

  task automatic checkOutput(input string tag, input logic [SW-1:0] observed,
                             input logic [SW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setRequest(input logic [TW-1:0] tag);
    for (int w = 0; w < SW / 32; w++) req_tdata[w*32 +: 32] = $urandom();
    req_tdata[TW-1:0] = tag;
  endtask

  // One clock: note handshakes before the edge, advance the model, check outputs.
  task automatic applyStimulus();
    bit            hs_req, hs_mem, hs_rsp, rsp_in, mem_stall, rsp_stall, fetching;
    logic [TW-1:0] req_tag;
    logic [AW-1:0] addr_before;
    logic [SW-1:0] line_before;
    hs_req      = req_tvalid && req_tready;
    hs_mem      = mem_req_valid && mem_req_ready;
    hs_rsp      = rsp_tvalid && rsp_tready;
    rsp_in      = mem_rsp_valid;
    mem_stall   = mem_req_valid && !mem_req_ready;
    rsp_stall   = rsp_tvalid && !rsp_tready;
    req_tag     = req_tdata[TW-1:0];
    addr_before = mem_req_addr;
    line_before = rsp_tdata;
    @(posedge clk);
    #1;
    if (rsp_in) begin
      if (in_service && received < issued) received++;
      else err_exp = 1;
    end
    if (hs_mem) begin
      issued++;
      mem_pending.push_back(addr_before);
    end
    if (hs_rsp) begin
      checkOutput("rsp_line", line_before, SW'(expected_line(cur_tag)));
      in_service = 0;
    end else if (!in_service && fifo_q.size() != 0) begin
      cur_tag    = fifo_q.pop_front();
      in_service = 1;
      issued     = 0;
      received   = 0;
    end
    if (hs_req) fifo_q.push_back(req_tag);
    rdy_exp  = (fifo_q.size() < DEPTH);
    fetching = in_service && received < BEATS && issued < BEATS;

    checkOutput("busy", busy, in_service || fifo_q.size() != 0);
    checkOutput("req_tready", req_tready, rdy_exp);
    checkOutput("mem_req_valid", mem_req_valid, fetching);
    if (fetching) checkOutput("mem_req_addr", mem_req_addr, {cur_tag, 3'(issued)});
    checkOutput("rsp_tvalid", rsp_tvalid, in_service && received == BEATS);
    checkOutput("err", err_unexpected_rsp, err_exp);
    if (mem_stall) checkOutput("addr_hold", mem_req_addr, addr_before);
    if (rsp_stall) checkOutput("tdata_hold", rsp_tdata, line_before);

    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (mem_pending.size() != 0) begin
      if (gap_cnt > 0) gap_cnt--;
      else begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_word(mem_pending.pop_front());
        gap_cnt       = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      end
    end
    case (ready_mode)
      0:       mem_req_ready = 1'b1;
      1:       mem_req_ready = ~mem_req_ready;
      default: mem_req_ready = 1'($urandom_range(1, 0));
    endcase
  endtask

  task automatic runUntilIdle(input int budget);
    int n = 0;
    while ((in_service || fifo_q.size() != 0) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_timeout", in_service || fifo_q.size() != 0, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_mem_req_valid"}, mem_req_valid, 0);
    checkOutput({tag, "_mem_req_addr"}, mem_req_addr, 0);
    checkOutput({tag, "_rsp_tvalid"}, rsp_tvalid, 0);
    checkOutput({tag, "_rsp_tdata"}, rsp_tdata, 0);
    checkOutput({tag, "_err"}, err_unexpected_rsp, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_req_tready"}, req_tready, 0);
  endtask

  initial begin
    int n;
    #2;
    checkResetOutputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    checkOutput("ready_before_first_edge", req_tready, 0);
    ready_mode = 0;
    rsp_tready = 1'b1;
    applyStimulus();

    $display("[TB] single fetch");
    setRequest(48'h0000DEADC0DE);
    req_tvalid = 1'b1;
    applyStimulus();
    req_tvalid = 1'b0;
    n = 1;
    while (!rsp_tvalid && n < 40) begin
      applyStimulus();
      n++;
    end
    checkOutput("rsp_latency", n, BEATS + 3);
    runUntilIdle(50);

    $display("[TB] issue backpressure");
    ready_mode = 1;
    setRequest(48'h0000DEADC0DE);
    req_tvalid = 1'b1;
    applyStimulus();
    req_tvalid = 1'b0;
    runUntilIdle(100);

    $display("[TB] random traffic with variable latency");
    ready_mode = 2;
    max_gap    = 4;
    for (int c = 0; c < 150; c++) begin
      req_tvalid = 1'($urandom_range(3, 0) == 0);
      setRequest(TW'({$urandom(), $urandom()}));
      rsp_tready = 1'($urandom_range(1, 0));
      applyStimulus();
    end
    req_tvalid = 1'b0;
    rsp_tready = 1'b1;
    runUntilIdle(2000);

    $display("[TB] fifo full and response stall");
    ready_mode = 0;
    max_gap    = 0;
    rsp_tready = 1'b0;
    n = 0;
    req_tvalid = 1'b1;
    do begin
      setRequest(TW'({$urandom(), $urandom()}));
      applyStimulus();
      n++;
    end while (req_tready && n < 20);
    checkOutput("fifo_full_ready", req_tready, 0);
    repeat (12) applyStimulus();
    req_tvalid = 1'b0;
    checkOutput("stall_no_mem_req", mem_req_valid, 0);
    rsp_tready = 1'b1;
    runUntilIdle(300);
    checkOutput("ready_after_drain", req_tready, 1);

    $display("[TB] unexpected response");
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h1234;
    applyStimulus();
    checkOutput("err_set", err_unexpected_rsp, 1);
    setRequest(TW'({$urandom(), $urandom()}));
    req_tvalid = 1'b1;
    applyStimulus();
    req_tvalid = 1'b0;
    runUntilIdle(50);
    checkOutput("err_sticky", err_unexpected_rsp, 1);

    $display("[TB] reset mid-fetch");
    setRequest(48'h0000CAFEF00D);
    req_tvalid = 1'b1;
    applyStimulus();
    setRequest(48'h000011112222);
    applyStimulus();
    req_tvalid = 1'b0;
    n = 0;
    while (issued < 3 && n < 40) begin
      applyStimulus();
      n++;
    end
    checkOutput("reach_beat3", issued, 3);
    rstn = 1'b0;
    #1;
    checkResetOutputs("midreset");
    fifo_q.delete();
    mem_pending.delete();
    in_service    = 0;
    err_exp       = 0;
    gap_cnt       = 0;
    mem_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    checkOutput("ready_after_release", req_tready, 0);
    applyStimulus();
    setRequest(48'h0000BEEF0042);
    req_tvalid = 1'b1;
    applyStimulus();
    req_tvalid = 1'b0;
    runUntilIdle(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
